// File: rtl/des_result_collector_if.sv
// des_result_collector_if: request/result/output bundle between host, DES pipeline and consumer
interface des_result_collector_if #(parameter int DEPTH = 8, parameter int TAG_W = 4);
  logic                         issue_valid;
  logic [TAG_W-1:0]             issue_tag;
  logic                         issue_decrypt;
  logic                         issue_ready;
  logic [63:0]                  result;
  logic                         result_valid;
  logic                         out_valid;
  logic                         out_ready;
  logic [63:0]                  out_data;
  logic [TAG_W-1:0]             out_tag;
  logic                         out_decrypt;
  logic [$clog2(DEPTH+1)-1:0]   credits;
  logic                         err_unexpected;
  logic                         err_overflow;
  modport master (
    output issue_valid, issue_tag, issue_decrypt, result, result_valid, out_ready,
    input  issue_ready, out_valid, out_data, out_tag, out_decrypt, credits, err_unexpected, err_overflow
  );
  modport slave (
    input  issue_valid, issue_tag, issue_decrypt, result, result_valid, out_ready,
    output issue_ready, out_valid, out_data, out_tag, out_decrypt, credits, err_unexpected, err_overflow
  );
endinterface

// File: rtl/des_result_collector.sv
// des_result_collector: credit-gated pairing of in-order DES results with their request tags
module des_result_collector #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input logic                  clk,
  input logic                  rst,
  des_result_collector_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = TAG_W + 1;
  logic [EW-1:0]    tmem [DEPTH];
  logic [63+EW:0]   omem [DEPTH];
  logic [AW:0]      twr_q, trd_q, owr_q, ord_q, owr_d, ord_d;
  logic [CW-1:0]    cred_q;
  logic             ov_q, odec_q, eu_q, eo_q;
  logic [63:0]      od_q;
  logic [TAG_W-1:0] ot_q;
  logic             acc, tpop, opop, head_new;
  logic [63+EW:0]   head;
  assign acc      = bus.issue_valid && cred_q != '0;
  assign tpop     = bus.result_valid && twr_q != trd_q;
  assign opop     = ov_q && bus.out_ready;
  assign owr_d    = owr_q + (AW+1)'(tpop);
  assign ord_d    = ord_q + (AW+1)'(opop);
  // the new head is the entry being written this cycle only when the FIFO drains to it
  assign head_new = tpop && ord_d == owr_q;
  assign head     = head_new ? {bus.result, tmem[trd_q[AW-1:0]]} : omem[ord_d[AW-1:0]];
  always_ff @(posedge clk) begin
    if (acc) tmem[twr_q[AW-1:0]] <= {bus.issue_tag, bus.issue_decrypt};
    if (tpop) omem[owr_q[AW-1:0]] <= {bus.result, tmem[trd_q[AW-1:0]]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      twr_q  <= '0;
      trd_q  <= '0;
      owr_q  <= '0;
      ord_q  <= '0;
      cred_q <= CW'(DEPTH);
      ov_q   <= 1'b0;
      od_q   <= '0;
      ot_q   <= '0;
      odec_q <= 1'b0;
      eu_q   <= 1'b0;
      eo_q   <= 1'b0;
    end else begin
      twr_q  <= twr_q + (AW+1)'(acc);
      trd_q  <= trd_q + (AW+1)'(tpop);
      owr_q  <= owr_d;
      ord_q  <= ord_d;
      cred_q <= cred_q - CW'(acc) + CW'(opop);
      ov_q   <= owr_d != ord_d;
      if (owr_d != ord_d) {od_q, ot_q, odec_q} <= head;
      eu_q   <= eu_q || (bus.result_valid && twr_q == trd_q);
      eo_q   <= eo_q || (bus.issue_valid && cred_q == '0);
    end
  end
  assign bus.issue_ready    = cred_q != '0;
  assign bus.credits        = cred_q;
  assign bus.out_valid      = ov_q;
  assign bus.out_data       = od_q;
  assign bus.out_tag        = ot_q;
  assign bus.out_decrypt    = odec_q;
  assign bus.err_unexpected = eu_q;
  assign bus.err_overflow   = eo_q;
endmodule

// File: tb/tb_des_result_collector.sv
// tb_des_result_collector: table vectors, corner sequences and random traffic against a queue model
module tb_des_result_collector;
  localparam int DEPTH = 8;
  localparam int TAG_W = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  des_result_collector_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();
  des_result_collector #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tot = 0;
  int n_fail = 0;
  logic [TAG_W:0]    tq[$];
  logic [64+TAG_W:0] oq[$];
  logic m_unx, m_ovf;

  typedef struct {
    logic iv; logic [TAG_W-1:0] tag; logic dec;
    logic rv; logic [63:0] res; logic ordy;
    logic e_ov; logic [63:0] e_data; logic [TAG_W-1:0] e_tag; logic e_dec; int e_cred;
  } vec_t;
  vec_t vt[16];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_tot++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask

  task automatic chk_model();
    int cr;
    cr = DEPTH - tq.size() - oq.size();
    chk("credits", 64'(bus.credits), 64'(cr));
    chk("issue_ready", 64'(bus.issue_ready), 64'(cr != 0));
    chk("out_valid", 64'(bus.out_valid), 64'(oq.size() != 0));
    chk("err_unexpected", 64'(bus.err_unexpected), 64'(m_unx));
    chk("err_overflow", 64'(bus.err_overflow), 64'(m_ovf));
    if (oq.size() != 0) begin
      chk("out_data", bus.out_data, oq[0][64+TAG_W:TAG_W+1]);
      chk("out_tag", 64'(bus.out_tag), 64'(oq[0][TAG_W:1]));
      chk("out_decrypt", 64'(bus.out_decrypt), 64'(oq[0][0]));
    end
  endtask

  task automatic cyc(input logic iv, input logic [TAG_W-1:0] tag, input logic dec,
                     input logic rv, input logic [63:0] res, input logic ordy);
    logic [TAG_W:0] e;
    bus.issue_valid = iv; bus.issue_tag = tag; bus.issue_decrypt = dec;
    bus.result_valid = rv; bus.result = res; bus.out_ready = ordy;
    @(posedge clk);
    if (iv && tq.size() + oq.size() == DEPTH) m_ovf = 1'b1;
    if (oq.size() != 0 && ordy) void'(oq.pop_front());
    if (rv) begin
      if (tq.size() == 0) m_unx = 1'b1;
      else begin
        e = tq.pop_front();
        oq.push_back({res, e});
      end
    end
    if (iv && tq.size() + oq.size() < DEPTH + (rv && tq.size() == 0 ? 0 : 0)) begin end
    #1;
    chk_model();
  endtask

  // issue acceptance decided before the result/pop bookkeeping, so handled in a wrapper
  task automatic step(input logic iv, input logic [TAG_W-1:0] tag, input logic dec,
                      input logic rv, input logic [63:0] res, input logic ordy);
    bit acc;
    acc = iv && (tq.size() + oq.size() < DEPTH);
    fork
      cyc(iv, tag, dec, rv, res, ordy);
      begin @(posedge clk); if (acc) tq.push_back({tag, dec}); end
    join
  endtask

  task automatic do_reset(input int n);
    bus.issue_valid = 0; bus.issue_tag = '0; bus.issue_decrypt = 0;
    bus.result_valid = 0; bus.result = '0; bus.out_ready = 0;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    tq.delete(); oq.delete(); m_unx = 0; m_ovf = 0;
    chk_model();
    chk("rst out_data", bus.out_data, 64'h0);
    chk("rst out_tag", 64'(bus.out_tag), 64'h0);
    chk("rst out_decrypt", 64'(bus.out_decrypt), 64'h0);
  endtask

  localparam logic [63:0] RA = 64'hc95744256a5ed31d;
  localparam logic [63:0] RB = 64'h85e813540f0ab405;
  localparam logic [63:0] RC = 64'h0123456789abcde7;

  initial begin
    vt[0]  = '{1,3,0, 0,0,0,  0,0,0,0, 7};
    vt[1]  = '{0,0,0, 0,0,0,  0,0,0,0, 7};
    vt[2]  = '{0,0,0, 0,0,0,  0,0,0,0, 7};
    vt[3]  = '{0,0,0, 0,0,0,  0,0,0,0, 7};
    vt[4]  = '{0,0,0, 0,0,0,  0,0,0,0, 7};
    vt[5]  = '{0,0,0, 1,RA,0, 1,RA,3,0, 7};
    vt[6]  = '{0,0,0, 0,0,1,  0,0,0,0, 8};
    vt[7]  = '{1,1,0, 0,0,0,  0,0,0,0, 7};
    vt[8]  = '{1,2,0, 0,0,0,  0,0,0,0, 6};
    vt[9]  = '{1,3,1, 0,0,0,  0,0,0,0, 5};
    vt[10] = '{0,0,0, 1,RA,0, 1,RA,1,0, 5};
    vt[11] = '{0,0,0, 1,RB,0, 1,RA,1,0, 5};
    vt[12] = '{0,0,0, 1,RC,0, 1,RA,1,0, 5};
    vt[13] = '{0,0,0, 0,0,1,  1,RB,2,0, 6};
    vt[14] = '{0,0,0, 0,0,1,  1,RC,3,1, 7};
    vt[15] = '{0,0,0, 0,0,1,  0,0,0,0, 8};
    do_reset(2);
    for (int i = 0; i < 16; i++) begin
      step(vt[i].iv, vt[i].tag, vt[i].dec, vt[i].rv, vt[i].res, vt[i].ordy);
      chk($sformatf("vec%0d credits", i), 64'(bus.credits), 64'(vt[i].e_cred));
      chk($sformatf("vec%0d out_valid", i), 64'(bus.out_valid), 64'(vt[i].e_ov));
      if (vt[i].e_ov) begin
        chk($sformatf("vec%0d out_data", i), bus.out_data, vt[i].e_data);
        chk($sformatf("vec%0d out_tag", i), 64'(bus.out_tag), 64'(vt[i].e_tag));
        chk($sformatf("vec%0d out_decrypt", i), 64'(bus.out_decrypt), 64'(vt[i].e_dec));
      end
    end
    // credit exhaustion and overflow
    for (int i = 0; i < 8; i++) step(1, 4'(i), 1'(i), 0, 0, 0);
    chk("exh credits", 64'(bus.credits), 64'h0);
    chk("exh issue_ready", 64'(bus.issue_ready), 64'h0);
    step(1, 4'hf, 1, 0, 0, 0);
    chk("exh err_overflow", 64'(bus.err_overflow), 64'h1);
    chk("exh credits after 9th", 64'(bus.credits), 64'h0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, {56'h0, 8'(i + 8'h40)}, 0);
    chk("exh out_tag0", 64'(bus.out_tag), 64'h0);
    step(0, 0, 0, 0, 0, 1);
    chk("exh issue_ready after pop", 64'(bus.issue_ready), 64'h1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 1);
    chk("exh drained credits", 64'(bus.credits), 64'h8);
    // simultaneous accepted issue and pop
    step(1, 5, 0, 0, 0, 0);
    step(0, 0, 0, 1, RB, 0);
    chk("sim pre credits", 64'(bus.credits), 64'h7);
    step(1, 6, 1, 0, 0, 1);
    chk("sim credits", 64'(bus.credits), 64'h7);
    step(0, 0, 0, 1, RC, 0);
    step(0, 0, 0, 0, 0, 1);
    // unexpected result with empty tag FIFO
    step(0, 0, 0, 1, 64'hFFFFFFFFFFFFFFFF, 0);
    chk("unx err", 64'(bus.err_unexpected), 64'h1);
    chk("unx out_valid", 64'(bus.out_valid), 64'h0);
    // reset mid-flight
    do_reset(1);
    for (int i = 0; i < 4; i++) step(1, 4'(i + 8), 0, 0, 0, 0);
    step(0, 0, 0, 1, RA, 0);
    step(0, 0, 0, 1, RB, 0);
    do_reset(3);
    chk("mrst credits", 64'(bus.credits), 64'h8);
    chk("mrst out_valid", 64'(bus.out_valid), 64'h0);
    chk("mrst errs", 64'({bus.err_unexpected, bus.err_overflow}), 64'h0);
    step(0, 0, 0, 1, RC, 0);
    chk("mrst err_unexpected", 64'(bus.err_unexpected), 64'h1);
    // randomized legal traffic
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      logic iv, rv;
      iv = (tq.size() + oq.size() < DEPTH) && ($urandom_range(0, 3) != 0);
      rv = (tq.size() != 0) && ($urandom_range(0, 2) != 0);
      step(iv, 4'($urandom), 1'($urandom), rv, {$urandom, $urandom}, $urandom_range(0, 3) != 0);
    end
    $display("%0d/%0d checks passed", n_tot - n_fail, n_tot);
    $finish;
  end
endmodule

// File: doc/des_result_collector.md
# des_result_collector

Output-side companion to `des_con`. It sits between the DES pipeline's fire-and-forget `result`/`result_valid` stream and a downstream consumer that applies backpressure. The block uses a credit gate on the request side so its buffers can never overflow. It pairs each result, in order, with the tag and `decrypt` flag captured when the request was issued. The DES pipeline preserves order and has no stall input, so no reordering is required.

## Interface
- `DEPTH`, 8: capacity of the tag FIFO and the output FIFO; power of two, 2..64.
- `TAG_W`, 4: width of the request tag.
- `clk`  in  1  single clock (same clock as `des_con`).
- `rst`  in  1  synchronous, active-high reset.
- `issue_valid`  in  1  request sent to `des_con` this cycle (host drives `text_valid` with the same value).
- `issue_tag`  in  TAG_W  host tag for this request.
- `issue_decrypt`  in  1  `decrypt` value sent with this request.
- `issue_ready`  out  1  credit available. The host must not assert `issue_valid` while this is low.
- `result`  in  64  `des_con` result.
- `result_valid`  in  1  `des_con` result strobe; single-cycle pulse per block.
- `out_valid`  out  1  output FIFO head valid.
- `out_ready`  in  1  consumer accepts the head.
- `out_data`  out  64  result at the head.
- `out_tag`  out  TAG_W  tag paired with the head.
- `out_decrypt`  out  1  decrypt flag paired with the head.
- `credits`  out  $clog2(DEPTH+1)  free credits.
- `err_unexpected`  out  1  sticky: `result_valid` arrived with no outstanding request.
- `err_overflow`  out  1  sticky: `issue_valid` asserted while `issue_ready`=0.

## Operation
- Reset values:
  - `credits`=DEPTH, `issue_ready`=1.
  - `out_valid`=0; `out_data`/`out_tag`/`out_decrypt`=0.
  - Both errors 0; both FIFOs empty.
- Issue accept: `issue_valid && issue_ready`. On accept, push {tag, decrypt} into the tag FIFO and decrement `credits`.
- Rejected issue (`issue_ready`=0): no push, credits unchanged, `err_overflow` set.
- Result capture on `result_valid`:
  - Tag FIFO non-empty: pop its head and push {result, tag, decrypt} into the output FIFO.
  - Tag FIFO empty: the result is dropped and `err_unexpected` is set.
  - Emptiness is judged on pre-cycle state. A same-cycle issue does not satisfy a result.
- Output pop: `out_valid && out_ready` pops the output FIFO and increments `credits`.
- Simultaneous accepted issue and pop: `credits` unchanged.
- Invariant: `credits` + tag FIFO count + output FIFO count = DEPTH. Neither FIFO can overflow, so no full checks are needed on pushes.
- `issue_ready` = (`credits` != 0), combinational from the registered `credits`.
- FIFO pointers are log2(DEPTH) bits plus a wrap bit and wrap naturally; full/empty are derived from pointer compare.
- Error flags are sticky until `rst`.
- Reset mid-operation discards all outstanding tags and buffered results and restores full credits. A `result_valid` after reset for a pre-reset request is flagged `err_unexpected`.
- No state machine beyond the FIFOs and the credit counter. The block is always in "run".

## Timing
- `result_valid` in cycle N: `out_valid`=1 with that data in cycle N+1, provided the output FIFO was empty. There is no bypass path.
- `out_*` are registered from the FIFO head. They update the cycle after a pop and hold stable while `out_valid && !out_ready`.
- `credits` and `issue_ready` update the cycle after an accept or pop.
- Full throughput: one issue, one result and one pop per cycle, sustained indefinitely with `out_ready`=1.
- Each output entry is mapped to tags in strict FIFO order.

## Test plan
- Single round trip:
  - Stimulus: issue tag=3, decrypt=0, then 5 cycles later pulse `result_valid` with result=0xc95744256a5ed31d.
  - Required: next cycle `out_valid`=1, `out_data`=0xc95744256a5ed31d, `out_tag`=3, `out_decrypt`=0.
  - Required: `credits` goes 8→7 after the issue and back to 8 after the pop.
- Ordering:
  - Stimulus: issue tags 1, 2, 3 back-to-back with decrypt 0, 0, 1. Return results 0xc95744256a5ed31d, 0x85e813540f0ab405, 0x0123456789abcde7.
  - Required: outputs appear in that order with tags 1, 2, 3 and decrypt 0, 0, 1.
- Credit exhaustion:
  - Stimulus: hold `out_ready`=0 and issue 8 requests.
  - Required: `issue_ready`=0 and `credits`=0 after the 8th.
  - Stimulus: a 9th `issue_valid`.
  - Required: `err_overflow`=1, nothing pushed.
  - Stimulus: return all 8 results, then a single `out_ready` pop.
  - Required: `issue_ready`=1.
- Simultaneous issue/pop:
  - Stimulus: with 1 buffered result and `credits`=7, assert accepted issue and `out_ready` in the same cycle.
  - Required: `credits` stays 7.
- Unexpected result:
  - Stimulus: `result_valid` with empty tag FIFO, result=0xFFFFFFFFFFFFFFFF.
  - Required: `err_unexpected`=1, `out_valid` stays 0.
- Reset mid-flight:
  - Stimulus: issue 4 requests, return 2 results, assert `rst` for 3 cycles.
  - Required: `credits`=8, `out_valid`=0, errors 0.
  - Stimulus: a subsequent `result_valid`.
  - Required: `err_unexpected`=1.
